// File: rtl/branch_predict_ctrl.sv
// Two-bit saturating-counter branch predictor with ID-stage resolution,
// misprediction redirect and saturating performance counters.
module branch_predict_ctrl #(
   parameter int         BHT_IDX_W  = 4,
   parameter int         CNT_W      = 16,
   parameter logic [1:0] INIT_STATE = 2'b01
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      pc_if,
   input  logic [5:0]       op_if,
   input  logic [5:0]       op_id,
   input  logic [31:0]      pc_id,
   input  logic [4:0]       rt_id,
   input  logic [31:0]      rf_rd1,
   input  logic [31:0]      rf_rd2,
   input  logic             pred_taken_id,
   input  logic [1:0]       Jump,
   input  logic             stall_id,
   output logic             pred_taken_if,
   output logic [1:0]       Branch,
   output logic             IF_flush,
   output logic [CNT_W-1:0] br_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   localparam int NENT = 1 << BHT_IDX_W;

   localparam logic [5:0] OP_REGIMM = 6'b000001;
   localparam logic [5:0] OP_BEQ    = 6'b000100;
   localparam logic [5:0] OP_BNE    = 6'b000101;
   localparam logic [5:0] OP_BLEZ   = 6'b000110;
   localparam logic [5:0] OP_BGTZ   = 6'b000111;

   logic [NENT-1:0][1:0]  bht_q, bht_d;
   logic [CNT_W-1:0]      br_cnt_q, br_cnt_d, mis_cnt_q, mis_cnt_d;
   logic [BHT_IDX_W-1:0]  idx_if, idx_id;
   logic                  is_br_if, is_br_id, taken_id, resolved, mispred;
   logic signed [31:0]    rs_s, rt_s;

   // Only the index bits of the PCs feed the table.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{pc_if[31:BHT_IDX_W+2], pc_if[1:0],
                             pc_id[31:BHT_IDX_W+2], pc_id[1:0]};

   assign idx_if = pc_if[BHT_IDX_W+1:2];
   assign idx_id = pc_id[BHT_IDX_W+1:2];
   assign rs_s   = rf_rd1;
   assign rt_s   = rf_rd2;

   // IF cannot see rt yet, so any REGIMM is treated as a branch there.
   assign is_br_if = (op_if == OP_REGIMM) || (op_if == OP_BEQ) || (op_if == OP_BNE) ||
                     (op_if == OP_BLEZ)   || (op_if == OP_BGTZ);

   assign pred_taken_if = is_br_if && bht_q[idx_if][1];

   always_comb begin
      is_br_id = 1'b1;
      taken_id = 1'b0;
      case (op_id)
         OP_BEQ:  taken_id = (rs_s == rt_s);
         OP_BNE:  taken_id = (rs_s != rt_s);
         OP_BLEZ: taken_id = (rs_s <= 0);
         OP_BGTZ: taken_id = (rs_s > 0);
         OP_REGIMM: begin
            if (rt_id == 5'b00000)      taken_id = (rs_s < 0);
            else if (rt_id == 5'b00001) taken_id = (rs_s >= 0);
            else                        is_br_id = 1'b0;
         end
         default: is_br_id = 1'b0;
      endcase
   end

   assign resolved = is_br_id && !stall_id;
   assign mispred  = resolved && (taken_id != pred_taken_id);

   always_comb begin
      Branch = 2'b00;
      if (mispred)            Branch = taken_id ? 2'b10 : 2'b11;
      else if (pred_taken_if) Branch = 2'b01;
   end

   assign IF_flush = mispred || ((Jump == 2'b01) && !stall_id);

   always_comb begin
      bht_d     = bht_q;
      br_cnt_d  = br_cnt_q;
      mis_cnt_d = mis_cnt_q;
      if (resolved) begin
         if (taken_id && bht_q[idx_id] != 2'b11)
            bht_d[idx_id] = bht_q[idx_id] + 2'b01;
         else if (!taken_id && bht_q[idx_id] != 2'b00)
            bht_d[idx_id] = bht_q[idx_id] - 2'b01;
         if (br_cnt_q != '1) br_cnt_d = br_cnt_q + 1'b1;
      end
      if (mispred && mis_cnt_q != '1) mis_cnt_d = mis_cnt_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         bht_q     <= {NENT{INIT_STATE}};
         br_cnt_q  <= '0;
         mis_cnt_q <= '0;
      end else begin
         bht_q     <= bht_d;
         br_cnt_q  <= br_cnt_d;
         mis_cnt_q <= mis_cnt_d;
      end
   end

   assign br_cnt      = br_cnt_q;
   assign mispred_cnt = mis_cnt_q;

endmodule

// File: tb/tb_branch_predict_ctrl.sv
// Directed bench for branch_predict_ctrl with a reference model and
// expected-result queues for the combinational and registered outputs.
module tb_branch_predict_ctrl;

   localparam int CW = 4;

   logic          clk = 1'b0;
   logic          rst;
   logic [31:0]   pc_if, pc_id, rf_rd1, rf_rd2;
   logic [5:0]    op_if, op_id;
   logic [4:0]    rt_id;
   logic          pred_taken_id, stall_id;
   logic [1:0]    Jump;
   logic          pred_taken_if, IF_flush;
   logic [1:0]    Branch;
   logic [CW-1:0] br_cnt, mispred_cnt;

   branch_predict_ctrl #(.BHT_IDX_W(4), .CNT_W(CW), .INIT_STATE(2'b01)) dut (
      .clk(clk), .rst(rst), .pc_if(pc_if), .op_if(op_if), .op_id(op_id),
      .pc_id(pc_id), .rt_id(rt_id), .rf_rd1(rf_rd1), .rf_rd2(rf_rd2),
      .pred_taken_id(pred_taken_id), .Jump(Jump), .stall_id(stall_id),
      .pred_taken_if(pred_taken_if), .Branch(Branch), .IF_flush(IF_flush),
      .br_cnt(br_cnt), .mispred_cnt(mispred_cnt)
   );

   always #5 clk = ~clk;

   typedef struct { logic pred; logic [1:0] br; logic fl; } comb_t;
   typedef struct { int bc; int mc; int ent; int idx; } seq_t;

   comb_t comb_q[$];
   seq_t  seq_q[$];
   int    m_bht[16];
   int    m_br, m_mis;
   int    checks = 0, errors = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic bit m_br_if(input logic [5:0] op);
      return op == 6'd1 || op == 6'd4 || op == 6'd5 || op == 6'd6 || op == 6'd7;
   endfunction

   function automatic bit m_br_id(input logic [5:0] op, input logic [4:0] rt);
      if (op == 6'd1) return rt == 5'd0 || rt == 5'd1;
      return op == 6'd4 || op == 6'd5 || op == 6'd6 || op == 6'd7;
   endfunction

   function automatic bit m_taken(input logic [5:0] op, input logic [4:0] rt,
                                  input logic [31:0] a, input logic [31:0] b);
      int sa, sb;
      sa = a; sb = b;
      case (op)
         6'd4: return sa == sb;
         6'd5: return sa != sb;
         6'd6: return sa <= 0;
         6'd7: return sa > 0;
         default: return (rt == 5'd0) ? (sa < 0) : (sa >= 0);
      endcase
   endfunction

   function automatic int ix(input logic [31:0] pc);
      return int'(pc[5:2]);
   endfunction

   // One cycle: drive, check combinational outputs before the edge, check
   // counters and the ID-indexed entry after the edge.
   task automatic step(input string tag, input logic r, input logic [31:0] pci,
                       input logic [5:0] opi, input logic [5:0] opd, input logic [31:0] pcd,
                       input logic [4:0] rt, input logic [31:0] a, input logic [31:0] b,
                       input logic pid, input logic [1:0] j, input logic st);
      comb_t e;
      seq_t  s;
      bit    res, tk, mp;
      rst = r; pc_if = pci; op_if = opi; op_id = opd; pc_id = pcd; rt_id = rt;
      rf_rd1 = a; rf_rd2 = b; pred_taken_id = pid; Jump = j; stall_id = st;
      res = m_br_id(opd, rt) && !st;
      tk  = res && m_taken(opd, rt, a, b);
      mp  = res && (tk != pid);
      e.pred = m_br_if(opi) && (m_bht[ix(pci)] >= 2);
      e.br   = mp ? (tk ? 2'b10 : 2'b11) : (e.pred ? 2'b01 : 2'b00);
      e.fl   = mp || (j == 2'b01 && !st);
      comb_q.push_back(e);
      #3;
      e = comb_q.pop_front();
      chk({tag, ".pred"},  {31'd0, pred_taken_if}, {31'd0, e.pred});
      chk({tag, ".Branch"}, {30'd0, Branch},       {30'd0, e.br});
      chk({tag, ".flush"}, {31'd0, IF_flush},      {31'd0, e.fl});
      if (r) begin
         for (int i = 0; i < 16; i++) m_bht[i] = 1;
         m_br = 0; m_mis = 0;
      end else if (res) begin
         if (tk && m_bht[ix(pcd)] < 3) m_bht[ix(pcd)]++;
         if (!tk && m_bht[ix(pcd)] > 0) m_bht[ix(pcd)]--;
         if (m_br < 15) m_br++;
         if (mp && m_mis < 15) m_mis++;
      end
      s.bc = m_br; s.mc = m_mis; s.idx = ix(pcd); s.ent = m_bht[ix(pcd)];
      seq_q.push_back(s);
      @(posedge clk); #1;
      s = seq_q.pop_front();
      chk({tag, ".br_cnt"},  {28'd0, br_cnt},      s.bc);
      chk({tag, ".mis_cnt"}, {28'd0, mispred_cnt}, s.mc);
      chk({tag, ".entry"},   {30'd0, dut.bht_q[s.idx]}, s.ent);
   endtask

   initial begin
      for (int i = 0; i < 16; i++) m_bht[i] = 0;
      m_br = 0; m_mis = 0;
      @(posedge clk); #1;
      step("rst0", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      step("rst1", 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 16; i++) chk("reset_entry", {30'd0, dut.bht_q[i]}, 32'd1);
      chk("reset_br", {28'd0, br_cnt}, 32'd0);

      // BEQ predicted not-taken in IF, then mispredicted taken in ID
      step("if_beq", 0, 32'h40, 6'd4, 0, 0, 0, 0, 0, 0, 0, 0);
      chk("if_beq_const", {30'd0, Branch}, 32'd0);
      step("id_beq", 0, 0, 0, 6'd4, 32'h40, 0, 5, 5, 0, 0, 0);
      chk("id_beq_entry", {30'd0, dut.bht_q[0]}, 32'd2);
      chk("id_beq_mis", {28'd0, mispred_cnt}, 32'd1);

      // Saturate entry 0, with IF reading the same entry during updates
      for (int k = 0; k < 5; k++)
         step("sat", 0, 32'h40, 6'd4, 6'd4, 32'h40, 0, 7, 7, 1, 0, 0);
      chk("sat_entry", {30'd0, dut.bht_q[0]}, 32'd3);
      step("if_taken", 0, 32'h40, 6'd4, 0, 0, 0, 0, 0, 0, 0, 0);

      // BGTZ with most-negative operand: not taken, predicted taken
      step("bgtz", 0, 32'h44, 6'd1, 6'd7, 32'h40, 0, 32'h8000_0000, 0, 1, 0, 0);
      chk("bgtz_entry", {30'd0, dut.bht_q[0]}, 32'd2);

      // REGIMM with unknown rt is no branch
      step("regimm_rt2", 0, 0, 0, 6'd1, 32'h40, 5'd2, 0, 0, 1, 0, 0);
      // Remaining opcodes
      step("bne",  0, 0, 0, 6'd5, 32'h48, 0, 1, 2, 0, 0, 0);
      step("blez", 0, 0, 0, 6'd6, 32'h4c, 0, 0, 0, 1, 0, 0);
      step("bltz", 0, 0, 0, 6'd1, 32'h50, 5'd0, 32'hFFFF_FFFF, 0, 0, 0, 0);
      step("bgez", 0, 0, 0, 6'd1, 32'h54, 5'd1, 32'hFFFF_FFFF, 0, 1, 0, 0);
      step("blez_pos", 0, 0, 0, 6'd6, 32'h58, 0, 3, 0, 1, 0, 0);

      // Stalled misprediction: IF-side only, then a single redirect
      step("stall_mp", 0, 32'h40, 6'd4, 6'd4, 32'h60, 0, 9, 9, 0, 2'b01, 1);
      step("stall_rel", 0, 32'h40, 6'd4, 6'd4, 32'h60, 0, 9, 9, 0, 0, 0);
      step("after_rel", 0, 32'h40, 6'd4, 0, 32'h60, 0, 9, 9, 0, 0, 0);

      // Jumps, alone and with a not-taken misprediction
      step("jump", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b01, 0);
      step("jump_mp", 0, 0, 0, 6'd5, 32'h64, 0, 4, 4, 1, 2'b01, 0);
      step("jump_other", 0, 0, 0, 0, 0, 0, 0, 0, 0, 2'b10, 0);

      // Drive mispred_cnt to max-1, then two more mispredicts
      while (m_mis < 14)
         step("mis_fill", 0, 0, 0, 6'd4, 32'h68, 0, 1, 1, 0, 0, 0);
      step("mis_sat0", 0, 0, 0, 6'd4, 32'h68, 0, 1, 1, 0, 0, 0);
      step("mis_sat1", 0, 0, 0, 6'd4, 32'h68, 0, 1, 1, 0, 0, 0);
      chk("mis_sat_const", {28'd0, mispred_cnt}, 32'hF);
      chk("br_sat_const",  {28'd0, br_cnt},      32'hF);

      // Reset overrides a same-cycle resolution
      step("rst_res", 1, 32'h40, 6'd4, 6'd4, 32'h40, 0, 1, 1, 0, 0, 0);
      for (int i = 0; i < 16; i++) chk("rst_res_entry", {30'd0, dut.bht_q[i]}, 32'd1);
      chk("rst_res_mis", {28'd0, mispred_cnt}, 32'd0);
      step("post_rst", 0, 32'h40, 6'd4, 0, 0, 0, 0, 0, 0, 0, 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
